// File: rtl/wb_burst_master_if.sv
// wb_burst_master_if: Wishbone B3 initiator/responder signal bundle
interface wb_burst_master_if #(parameter int ADR_WIDTH = 16);
  logic                 cyc_o;
  logic                 stb_o;
  logic                 we_o;
  logic [ADR_WIDTH-1:2] adr_o;
  logic [3:0]           sel_o;
  logic [2:0]           cti_o;
  logic [31:0]          dat_o;
  logic [31:0]          dat_i;
  logic                 ack_i;
  modport master (output cyc_o, stb_o, we_o, adr_o, sel_o, cti_o, dat_o, input dat_i, ack_i);
  modport slave  (input cyc_o, stb_o, we_o, adr_o, sel_o, cti_o, dat_o, output dat_i, ack_i);
endinterface

// File: rtl/wb_burst_master.sv
// wb_burst_master: Wishbone B3 incrementing-burst initiator buffered through one shared FIFO
module wb_burst_master #(
  parameter int ADR_WIDTH  = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_we_i,
  input  logic [ADR_WIDTH-3:0] cmd_adr_i,
  input  logic [LEN_W-1:0]     cmd_len_i,
  input  logic [31:0]          wr_data_i,
  input  logic                 wr_valid_i,
  output logic                 wr_ready_o,
  output logic [31:0]          rd_data_o,
  output logic                 rd_valid_o,
  input  logic                 rd_ready_i,
  output logic                 done_o,
  wb_burst_master_if.master    wb
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, FILL, BURST, DONE} state_t;
  state_t st;
  logic we, empty, acc, cap, ack, go, push, pop;
  logic [LEN_W-1:0] len, cnt, beats, len_c, go_len;
  logic [AW:0] wp, rp;
  logic [31:0] mem [FIFO_DEPTH];
  logic [31:0] push_d;
  assign empty       = wp == rp;
  assign cmd_ready_o = st == IDLE && empty;
  assign acc         = cmd_valid_i && cmd_ready_o;
  assign len_c       = cmd_len_i > LEN_W'(FIFO_DEPTH) ? LEN_W'(FIFO_DEPTH) : cmd_len_i;
  assign wr_ready_o  = st == FILL && cnt < len;
  assign cap         = wr_valid_i && wr_ready_o;
  assign ack         = st == BURST && wb.ack_i;
  // write data also lives in the FIFO, so hide it from the read stream
  assign rd_valid_o  = !empty && !we;
  assign rd_data_o   = mem[rp[AW-1:0]];
  assign wb.dat_o    = st == BURST && we ? mem[rp[AW-1:0]] : '0;
  assign push        = cap || (ack && !we);
  assign push_d      = cap ? wr_data_i : wb.dat_i;
  assign pop         = (ack && we) || (rd_valid_o && rd_ready_i);
  assign go          = (acc && len_c != '0 && !cmd_we_i) || (cap && cnt + 1'b1 == len);
  assign go_len      = st == FILL ? len : len_c;
  always_ff @(posedge clk_i)
    if (push) mem[wp[AW-1:0]] <= push_d;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      st        <= IDLE;
      wp        <= '0;
      rp        <= '0;
      we        <= 1'b0;
      len       <= '0;
      cnt       <= '0;
      beats     <= '0;
      done_o    <= 1'b0;
      wb.cyc_o  <= 1'b0;
      wb.stb_o  <= 1'b0;
      wb.we_o   <= 1'b0;
      wb.sel_o  <= 4'b0000;
      wb.cti_o  <= 3'b000;
      wb.adr_o  <= '0;
    end else begin
      wp     <= wp + (AW+1)'(push);
      rp     <= rp + (AW+1)'(pop);
      done_o <= 1'b0;
      case (st)
        IDLE: if (acc) begin
          we       <= cmd_we_i;
          len      <= len_c;
          beats    <= len_c;
          cnt      <= '0;
          wb.adr_o <= cmd_adr_i;
          st       <= len_c == '0 ? DONE : cmd_we_i ? FILL : BURST;
          done_o   <= len_c == '0;
        end
        FILL: if (cap) begin
          cnt <= cnt + 1'b1;
          st  <= cnt + 1'b1 == len ? BURST : FILL;
        end
        BURST: if (wb.ack_i) begin
          wb.adr_o <= wb.adr_o + 1'b1;
          beats    <= beats - 1'b1;
          wb.cti_o <= beats == LEN_W'(2) ? 3'b111 : 3'b010;
          if (beats == LEN_W'(1)) begin
            st       <= DONE;
            done_o   <= 1'b1;
            wb.cyc_o <= 1'b0;
            wb.stb_o <= 1'b0;
            wb.we_o  <= 1'b0;
            wb.sel_o <= 4'b0000;
            wb.cti_o <= 3'b000;
          end
        end
        DONE: st <= IDLE;
      endcase
      if (go) begin
        wb.cyc_o <= 1'b1;
        wb.stb_o <= 1'b1;
        wb.sel_o <= 4'b1111;
        wb.we_o  <= st == FILL;
        wb.cti_o <= go_len == LEN_W'(1) ? 3'b111 : 3'b010;
      end
    end
endmodule

// File: tb/tb_wb_burst_master.sv
// tb_wb_burst_master: table-driven and randomized bursts against a queue-based transaction model
module tb_wb_burst_master;
  localparam int AW = 16, DEPTH = 16, LW = 5;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic cmd_valid = 0, cmd_ready, cmd_we = 0;
  logic [AW-3:0] cmd_adr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [31:0] wr_data = '0, rd_data;
  logic wr_valid = 0, wr_ready, rd_valid, rd_ready = 0, done_o;
  wb_burst_master_if #(.ADR_WIDTH(AW)) wb();
  wb_burst_master #(.ADR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .LEN_W(LW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_we_i(cmd_we), .cmd_adr_i(cmd_adr), .cmd_len_i(cmd_len),
    .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
    .done_o(done_o), .wb(wb));
  logic [31:0] ram [0:16383];
  logic [31:0] model [0:16383];
  assign wb.dat_i = ram[wb.adr_o];
  int exp_adr[$];
  logic [2:0] exp_cti[$];
  logic [31:0] exp_dat[$], wr_q[$], rd_q[$];
  bit exp_we, expect_done, expect_cyc;
  int ack_pct = 0, rd_pct = 0, wr_pct = 100;
  int tests = 0, fails = 0, done_cnt = 0, beats_done = 0;
  int m_a;
  logic [2:0] m_c;
  logic [31:0] m_d;
  typedef struct { bit we; int adr; int len; int apct; int rpct; int exp_beats; } vec_t;
  vec_t vecs[10];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // responder, stream driver and per-beat checker
  always @(negedge clk)
    if (rst_n) begin
      if (expect_done) begin
        chk("done_after_last_ack", {done_o, wb.cyc_o, wb.stb_o}, 3'b100);
        expect_done = 0;
      end
      if (expect_cyc) begin
        chk("cyc_after_last_wr", wb.cyc_o, 1);
        expect_cyc = 0;
      end
      if (done_o) done_cnt++;
      if (wb.cyc_o) begin
        chk("bus_ctl", {wb.stb_o, wb.sel_o, wb.we_o, exp_adr.size() != 0}, {1'b1, 4'hf, exp_we, 1'b1});
        wb.ack_i = $urandom_range(1, 100) <= ack_pct;
        if (wb.ack_i && exp_adr.size() != 0) begin
          m_a = exp_adr.pop_front();
          m_c = exp_cti.pop_front();
          chk("beat_adr", wb.adr_o, m_a);
          chk("beat_cti", wb.cti_o, m_c);
          if (exp_we) begin
            m_d = exp_dat.pop_front();
            chk("beat_dat", wb.dat_o, m_d);
            ram[wb.adr_o] = wb.dat_o;
          end
          beats_done++;
          if (exp_adr.size() == 0) expect_done = 1;
        end
      end else begin
        chk("idle_bus", {wb.stb_o, wb.sel_o, wb.cti_o}, 0);
        wb.ack_i = $urandom_range(1, 100) <= 10;
      end
      rd_ready = $urandom_range(1, 100) <= rd_pct;
      if (rd_valid && rd_ready) begin
        chk("rd_expected", rd_q.size() != 0, 1);
        if (rd_q.size() != 0) chk("rd_data", rd_data, rd_q.pop_front());
      end
      wr_valid = wr_q.size() != 0 && $urandom_range(1, 100) <= wr_pct;
      wr_data = wr_valid ? wr_q[0] : $urandom;
      if (wr_valid && wr_ready) begin
        void'(wr_q.pop_front());
        if (wr_q.size() == 0) expect_cyc = 1;
      end
    end else begin
      wb.ack_i = 0;
      rd_ready = 0;
      wr_valid = 0;
    end

  task automatic issue(bit we, int adr, int len, int n);
    logic [31:0] w;
    int a;
    exp_we = we;
    beats_done = 0;
    for (int i = 0; i < n; i++) begin
      a = (adr + i) & 16'h3FFF;
      exp_adr.push_back(a);
      exp_cti.push_back(i == n - 1 ? 3'b111 : 3'b010);
      if (we) begin
        w = $urandom;
        exp_dat.push_back(w);
        wr_q.push_back(w);
        model[a] = w;
      end else rd_q.push_back(model[a]);
    end
    cmd_we = we;
    cmd_adr = adr[13:0];
    cmd_len = len[4:0];
    cmd_valid = 1;
    for (int t = 0; !cmd_ready; t++) begin
      if (t > 300) begin
        chk("cmd_accept_timeout", 1, 0);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    cmd_valid = 0;
    chk("first_cycle", {wb.cyc_o, done_o}, {n > 0 && !we, n == 0});
  endtask

  task automatic run_cmd(bit we, int adr, int len, int n, int apct, int rpct);
    int d0;
    ack_pct = apct;
    rd_pct = rpct;
    wr_pct = $urandom_range(40, 100);
    d0 = done_cnt;
    issue(we, adr, len, n);
    for (int t = 0; done_cnt == d0; t++) begin
      if (t > 2000) begin
        chk("done_timeout", 1, 0);
        break;
      end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("done_once", done_cnt - d0, 1);
    chk("beats_all", {exp_adr.size(), wr_q.size()}, 0);
  endtask

  task automatic drain();
    rd_pct = 100;
    for (int t = 0; rd_q.size() != 0 || rd_valid; t++) begin
      if (t > 200) break;
      @(negedge clk);
    end
    @(negedge clk);
    chk("drained", {rd_q.size(), 31'(0), rd_valid, cmd_ready}, {32'd0, 31'(0), 1'b0, 1'b1});
  endtask

  initial begin
    vecs = '{
      '{1, 'h010, 4, 100, 100, 4},
      '{0, 'h010, 4, 100, 100, 4},
      '{0, 'h020, 1, 100, 100, 1},
      '{1, 'h3FFF, 3, 60, 100, 3},
      '{0, 'h3FFF, 3, 100, 100, 3},
      '{1, 'h100, 0, 100, 100, 0},
      '{1, 'h200, 20, 50, 100, 16},
      '{0, 'h200, 31, 70, 40, 16},
      '{1, 'h050, 2, 30, 100, 2},
      '{0, 'h050, 2, 30, 70, 2}};
    for (int i = 0; i < 16384; i++) begin
      ram[i] = {i[15:0], ~i[15:0]};
      model[i] = {i[15:0], ~i[15:0]};
    end
    #12;
    chk("reset_bus", {wb.cyc_o, wb.stb_o, wb.we_o, wb.sel_o, wb.cti_o}, 0);
    chk("reset_adr_dat", {wb.adr_o, wb.dat_o}, 0);
    chk("reset_stream", {done_o, wr_ready, rd_valid, cmd_ready}, 4'b0001);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("post_reset", {wb.cyc_o, done_o, rd_valid, cmd_ready}, 4'b0001);
    foreach (vecs[i]) begin
      run_cmd(vecs[i].we, vecs[i].adr, vecs[i].len, vecs[i].exp_beats, vecs[i].apct, vecs[i].rpct);
      drain();
    end
    // full buffer held with the read stream stalled
    run_cmd(0, 'h400, 16, 16, 100, 0);
    chk("buffered_hold", {cmd_ready, rd_valid}, 2'b01);
    drain();
    // reset asserted during beat 2 of an 8-beat read
    ack_pct = 100;
    rd_pct = 0;
    issue(0, 'h500, 8, 8);
    for (int t = 0; beats_done < 2 && t < 100; t++) begin
      @(negedge clk);
      #1;
    end
    chk("reached_beat2", beats_done, 2);
    #1 rst_n = 0;
    #1 chk("reset_mid_burst", {wb.cyc_o, wb.stb_o}, 0);
    exp_adr.delete();
    exp_cti.delete();
    rd_q.delete();
    expect_done = 0;
    ack_pct = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("after_mid_reset", {cmd_ready, rd_valid, wb.cyc_o, done_o}, 4'b1000);
    for (int k = 0; k < 25; k++) begin
      int len, adr;
      bit we;
      we = 1'($urandom_range(0, 1));
      adr = $urandom_range(0, 16383);
      len = $urandom_range(0, 20);
      run_cmd(we, adr, len, len > DEPTH ? DEPTH : len, $urandom_range(30, 100), $urandom_range(20, 100));
      drain();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
